rng_collector: RTL and testbench

RNG_COLLECTOR -- requirements
Module: rng_collector

---
 rtl/rng_collector.sv | 135 +++++++++++++
 tb/tb_rng_collector.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rng_collector.sv
// Random-bit collector: edge-detects core strobes, von Neumann debiases raw bits,
// packs them LSB-first into words, queues words in a FIFO and runs a repetition-count health test.
module rng_collector #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int RCT_LIMIT = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             rnd_bit,
    input  logic             done,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overflow,
    output logic             health_fail,
    output logic [7:0]       drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_pack;
    logic [BW-1:0]    r_bitcnt;
    logic             r_done_d;
    logic             r_pair_have;
    logic             r_pair_first;
    logic             r_prev_bit;
    logic             r_prev_valid;
    logic [7:0]       r_run;
    logic             r_health;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;

    logic             w_event;
    logic             w_same;
    logic [7:0]       w_run_next;
    logic             w_trip;
    logic             w_dbit_valid;
    logic             w_word_done;
    logic [WIDTH-1:0] w_word;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // A raw event is the rising edge of done; everything is frozen once health has failed
    assign w_event      = done & ~r_done_d & ~r_health;
    assign w_same       = r_prev_valid & (rnd_bit == r_prev_bit);
    assign w_run_next   = !w_same ? 8'd1 : ((r_run == 8'hFF) ? r_run : r_run + 8'd1);
    assign w_trip       = w_event & (w_run_next == 8'(RCT_LIMIT));
    // Pair 10 yields 1 and 01 yields 0, so the debiased bit is simply the first of the pair
    assign w_dbit_valid = w_event & r_pair_have & (r_pair_first != rnd_bit);
    assign w_word       = {r_pair_first, r_pack[WIDTH-1:1]};
    assign w_word_done  = w_dbit_valid & (r_bitcnt == BW'(WIDTH - 1));
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_pop        = (r_count != {CW{1'b0}}) & word_ready;
    assign w_push       = w_word_done & (~w_full | w_pop) & ~w_trip;
    assign w_drop       = w_word_done & w_full & ~w_pop & ~w_trip;

    assign word_valid   = (r_count != {CW{1'b0}});
    assign word_out     = word_valid ? r_mem[r_rd_ptr] : {WIDTH{1'b0}};
    assign overflow     = r_overflow;
    assign health_fail  = r_health;
    assign drop_cnt     = r_drop_cnt;

    // Edge detect, debias, pack, FIFO, health and drop bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr     <= {AW{1'b0}};
            r_rd_ptr     <= {AW{1'b0}};
            r_count      <= {CW{1'b0}};
            r_pack       <= {WIDTH{1'b0}};
            r_bitcnt     <= {BW{1'b0}};
            r_done_d     <= 1'b1;
            r_pair_have  <= 1'b0;
            r_pair_first <= 1'b0;
            r_prev_bit   <= 1'b0;
            r_prev_valid <= 1'b0;
            r_run        <= 8'd0;
            r_health     <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_cnt   <= 8'd0;
        end else begin
            r_done_d <= done;

            if (r_health || w_trip) begin
                r_count  <= {CW{1'b0}};
                r_wr_ptr <= {AW{1'b0}};
                r_rd_ptr <= {AW{1'b0}};
                r_health <= 1'b1;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= w_word;
                    r_wr_ptr        <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end

            if (w_event) begin
                r_prev_bit   <= rnd_bit;
                r_prev_valid <= 1'b1;
                r_run        <= w_run_next;
                r_pair_have  <= ~r_pair_have;
                r_pair_first <= r_pair_have ? r_pair_first : rnd_bit;
            end

            if (w_dbit_valid) begin
                r_pack   <= w_word;
                r_bitcnt <= w_word_done ? {BW{1'b0}} : r_bitcnt + BW'(1);
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= (r_drop_cnt == 8'hFF) ? r_drop_cnt : r_drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rng_collector.sv
// Bench for rng_collector: table of raw-pair words with hand-derived expected words,
// a queue scoreboard compared on every pop, plus hand-written overflow, health and reset sequences.
module tb_rng_collector;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 4;
    localparam int RCT_LIMIT = 32;

    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    logic             rnd_bit = 1'b0;
    logic             done = 1'b0;
    logic             word_ready = 1'b0;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             overflow;
    logic             health_fail;
    logic [7:0]       drop_cnt;

    typedef struct {
        logic [15:0] pairs;
        logic [7:0]  exp;
    } vec_t;

    vec_t       tbl [5];
    logic [7:0] sb_q [$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [15:0] p4;

    rng_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RCT_LIMIT(RCT_LIMIT)) dut (
        .clk(clk), .rst_b(rst_b), .rnd_bit(rnd_bit), .done(done),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .overflow(overflow), .health_fail(health_fail), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted word must match the oldest expected word
    always @(negedge clk) begin
        if (rst_b === 1'b1 && word_valid === 1'b1 && word_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got 0x%0h, want no word", word_out);
            end else begin
                check("sb_word", 32'(word_out), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic raw_event(input logic b);
        @(posedge clk); #1; done = 1'b1; rnd_bit = b;
        @(posedge clk); #1; done = 1'b0;
    endtask

    task automatic feed_pair(input logic [1:0] p);
        raw_event(p[1]);
        raw_event(p[0]);
    endtask

    task automatic feed_word(input logic [15:0] pairs);
        for (int i = 7; i >= 0; i--) feed_pair(pairs[2*i+1 -: 2]);
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst_b = 1'b0; done = 1'b0; word_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst_b = 1'b1;
        sb_q.delete();
    endtask

    task automatic drain();
        @(posedge clk); #1; word_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && word_valid === 1'b0) break;
        end
        check("drain_done", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1; word_ready = 1'b0;
    endtask

    initial begin
        tbl[0] = '{16'b10_01_10_10_01_01_01_10, 8'h8D};
        tbl[1] = '{16'b10_10_10_10_10_10_10_10, 8'hFF};
        tbl[2] = '{16'b01_01_01_01_01_01_01_01, 8'h00};
        tbl[3] = '{16'b10_01_10_01_10_01_10_01, 8'h55};
        tbl[4] = '{16'b01_01_01_10_10_01_10_10, 8'hD8};

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_word", 32'(word_out), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_health", 32'(health_fail), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);

        // Table words, first word twice; each valid one cycle after its last done edge
        @(posedge clk); #1; word_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("idle_valid", 32'(word_valid), 32'd0);
            sb_q.push_back(tbl[(k == 0) ? 0 : k - 1].exp);
            feed_word(tbl[(k == 0) ? 0 : k - 1].pairs);
            @(negedge clk);
            check("latency_valid", 32'(word_valid), 32'd1);
        end

        // Discarded 00/11 pairs interleaved with valid pairs
        sb_q.push_back(tbl[0].exp);
        for (int i = 7; i >= 0; i--) begin
            feed_pair((i % 2 == 0) ? 2'b00 : 2'b11);
            feed_pair(tbl[0].pairs[2*i+1 -: 2]);
        end
        repeat (4) @(negedge clk);
        check("junk_one_word", 32'(sb_q.size()), 32'd0);

        // Overflow: DEPTH+2 words with no consumer
        do_reset();
        for (int k = 0; k < DEPTH + 2; k++) begin
            if (k < DEPTH) sb_q.push_back(tbl[k].exp);
            feed_word(tbl[k % 5].pairs);
            if (k == DEPTH - 1) begin
                @(negedge clk);
                check("ovf_at_full", 32'(overflow), 32'd0);
            end
        end
        @(negedge clk);
        check("ovf_valid", 32'(word_valid), 32'd1);
        check("ovf_head", 32'(word_out), 32'(tbl[0].exp));
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
        drain();
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_drop_kept", 32'(drop_cnt), 32'd2);

        // Full FIFO, word completes on the same edge as a pop
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            sb_q.push_back(tbl[k].exp);
            feed_word(tbl[k].pairs);
        end
        p4 = tbl[4].pairs;
        sb_q.push_back(tbl[4].exp);
        for (int i = 7; i >= 1; i--) feed_pair(p4[2*i+1 -: 2]);
        raw_event(p4[1]);
        @(posedge clk); #1; done = 1'b1; rnd_bit = p4[0]; word_ready = 1'b1;
        @(posedge clk); #1; done = 1'b0; word_ready = 1'b0;
        @(negedge clk);
        check("pushpop_overflow", 32'(overflow), 32'd0);
        check("pushpop_drop", 32'(drop_cnt), 32'd0);
        check("pushpop_valid", 32'(word_valid), 32'd1);
        drain();

        // Repetition-count failure on the 32nd identical raw bit
        do_reset();
        feed_word(tbl[0].pairs);
        for (int i = 1; i < RCT_LIMIT; i++) raw_event(1'b1);
        @(negedge clk);
        check("rct_before_health", 32'(health_fail), 32'd0);
        check("rct_before_valid", 32'(word_valid), 32'd1);
        raw_event(1'b1);
        @(negedge clk);
        check("rct_health", 32'(health_fail), 32'd1);
        check("rct_flush_valid", 32'(word_valid), 32'd0);
        @(posedge clk); #1; word_ready = 1'b1;
        feed_word(tbl[1].pairs);
        @(negedge clk);
        check("rct_ignored_valid", 32'(word_valid), 32'd0);
        check("rct_health_sticky", 32'(health_fail), 32'd1);
        do_reset();
        @(negedge clk);
        check("rct_reset_clears", 32'(health_fail), 32'd0);

        // done held high across reset release, then reset pulsed mid-word
        @(posedge clk); #1; rst_b = 1'b0; done = 1'b1; rnd_bit = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1; done = 1'b0;
        word_ready = 1'b1;
        sb_q.push_back(tbl[0].exp);
        feed_word(tbl[0].pairs);
        @(negedge clk);
        check("held_done_valid", 32'(word_valid), 32'd1);
        for (int i = 0; i < 5; i++) feed_pair(2'b10);
        do_reset();
        @(posedge clk); #1; word_ready = 1'b1;
        sb_q.push_back(tbl[3].exp);
        feed_word(tbl[3].pairs);
        @(negedge clk);
        check("post_reset_valid", 32'(word_valid), 32'd1);
        repeat (3) @(negedge clk);
        check("sb_final_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
